ms_load_queue: RTL
==================

Name: ms_load_queue

Overview:
- Parametrised successor to the single-entry memory stage.
- Holds up to DEPTH in-order memory-stage entries between EX and WB, so several loads can be outstanding on the data-sram req/data_ok bus at once.
- Each entry either waits for its in-order data_ok beat or carries a pass-through EX result. Load data is aligned and sign/zero-extended per load_op at the DATA_W bus width.
- On a pipeline flush, all queued entries are dropped and late responses belonging to flushed loads are silently discarded.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- DATA_W, 32, data-sram bus and result width; 32 or 64.
- DEST_W, 5, destination register index width.
- PC_W, 32, PC width carried for WB/trace.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX presents an entry.
- in_ready  out  1  queue accepts (= !full && !flush).
- in_mem_req  in  1  entry issued a data-sram load request this cycle.
- in_load_op  in  5  one-hot {hu,bu,w,h,b}; LSB = b.
- in_vaddr_lo  in  $clog2(DATA_W/8)  byte offset within bus word.
- in_dest  in  DEST_W  destination register.
- in_gr_we  in  1  register write enable.
- in_result  in  DATA_W  pass-through EX result.
- in_pc  in  PC_W  instruction PC.
- data_sram_data_ok  in  1  in-order response beat.
- data_sram_rdata  in  DATA_W  response data.
- flush  in  1  pipeline flush (exception/ertn from WB).
- out_valid  out  1  head entry complete.
- out_ready  in  1  WB accepts head.
- out_gr_we, out_dest, out_result, out_pc  out  1/DEST_W/DATA_W/PC_W  head fields.
- fwd_valid  out  1  head valid and gr_we (forwarding to ID).
- fwd_dest  out  DEST_W  head destination for forwarding.
- fwd_result  out  DATA_W  head result for forwarding.
- count  out  $clog2(DEPTH)+1  live entries.
- discard_cnt  out  $clog2(DEPTH)+1  pending responses still to be dropped.
- proto_err  out  1  sticky: data_ok arrived with nothing to match it.

Behaviour:
- Reset (async): rd/wr pointers 0, count 0, discard_cnt 0, proto_err 0; out_valid 0, fwd_valid 0, in_ready 1; data outputs 0.
- Entry state: {desc, data, done}.
  - Push with in_mem_req=0: done=1 at write, data=in_result.
  - Push with in_mem_req=1: done=0.
- Push handshake: push when in_valid && in_ready. full = (count + discard_cnt) >= DEPTH, because flushed responses still occupy bus slots.
- Response matching, priority order:
  1. If discard_cnt > 0: data_ok decrements discard_cnt; data is dropped.
  2. Else: data_ok writes data to the oldest entry with done=0 and sets its done bit. The oldest-pending pointer advances monotonically.
  3. Else (no pending entry): proto_err is set sticky and the beat is ignored.
- Output: out_valid = head.done && count>0 && !flush. Pop on out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- Alignment is applied on the response write; stored data is final.
  - b/bu: byte at in_vaddr_lo, sign/zero-extended to DATA_W.
  - h/hu: halfword at in_vaddr_lo[msb:1], sign/zero-extended.
  - w: word at in_vaddr_lo[msb:2]; sign-extended when DATA_W=64.
  - Non-one-hot load_op gives result 0.
- Flush: next cycle count=0 and pointers reset.
  - discard_cnt_next = discard_cnt + (pending entries with done=0) − (data_ok this cycle ? 1 : 0).
  - A same-cycle push is ignored (in_ready=0). A same-cycle pop does not occur (out_valid forced 0).
- Response latency: data_ok at cycle N gives out_valid at N+1 when the entry is the head.
- Pointer wrap: pointers wrap modulo DEPTH; count distinguishes full from empty.

Optional Feature:
- Macro: MS_LQ_BYPASS_EN.
- Defined: when the head has done=0 and the matched data_ok targets the head (discard_cnt=0), out_valid, out_result and fwd_* assert combinationally in the same cycle, carrying the aligned rdata. If popped that cycle, the entry is never written.
- Undefined: 1-cycle registered latency only.

Decomposition:
- Shared package: load_op bit positions (LOP_B, LOP_H, LOP_W, LOP_BU, LOP_HU) and the entry descriptor packed-struct layout.
- One sub-module, ms_load_align: combinational (rdata, vaddr_lo, load_op) -> DATA_W result, parametrised by DATA_W. Reused by the bypass path.

Test Plan:
- Single load, in_load_op=b, vaddr_lo=1, rdata=0x0000_80FF, data_ok 3 cycles after push -> out_result=0xFFFF_FF80 one cycle after data_ok; hu at vaddr_lo=2 with same data -> 0x0000_0000.
- Push 4 loads (DEPTH=4) back-to-back -> in_ready=0 after the 4th; data_ok ×4 with rdata 1..4 -> outputs 1,2,3,4 in order; out_ready toggled 1/0 holds head stable.
- Mixed: mem load, pass-through (in_result=0x55), mem load; pass-through must not overtake → outputs in push order; pass-through retired in the cycle after the first load pops.
- Flush with 3 pending loads and data_ok in the same cycle -> count=0, discard_cnt=2; next 2 data_ok dropped; a new load pushed after flush receives the 3rd beat; full asserts while count+discard_cnt=4.
- data_ok with queue empty and discard_cnt=0 -> proto_err=1 and remains set; async reset mid-burst clears all state without a clock edge.
- MS_LQ_BYPASS_EN build: head waiting, data_ok with rdata=0x1234 and out_ready=1 -> out_valid and out_result=0x1234 in the same cycle, count decrements next edge.

Source files
------------

// File: rtl/ms_load_queue_pkg.sv
// Shared definitions for the memory-stage load queue: load_op encoding and entry descriptor.
package ms_load_queue_pkg;

    localparam int LOP_B  = 0;
    localparam int LOP_H  = 1;
    localparam int LOP_W  = 2;
    localparam int LOP_BU = 3;
    localparam int LOP_HU = 4;

    typedef logic [4:0] load_op_t;

    localparam load_op_t OP_B  = load_op_t'(1) << LOP_B;
    localparam load_op_t OP_H  = load_op_t'(1) << LOP_H;
    localparam load_op_t OP_W  = load_op_t'(1) << LOP_W;
    localparam load_op_t OP_BU = load_op_t'(1) << LOP_BU;
    localparam load_op_t OP_HU = load_op_t'(1) << LOP_HU;

    // Width-independent part of an entry; dest/pc/offset/data live in per-field arrays.
    typedef struct packed {
        logic     gr_we;
        load_op_t load_op;
    } lq_desc_t;

endpackage

// File: rtl/ms_load_align.sv
// Load data alignment: selects byte/half/word at the bus offset and sign/zero-extends to DATA_W.
module ms_load_align
    import ms_load_queue_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int VLO_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [VLO_W-1:0]  vaddr_lo,
    input  load_op_t          load_op,
    output logic [DATA_W-1:0] result
);

    function automatic logic [DATA_W-1:0] ext8(input logic [7:0] v, input logic sgn);
        logic signed [DATA_W-1:0] s;
        s = DATA_W'($signed(v));
        return sgn ? DATA_W'(s) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] ext16(input logic [15:0] v, input logic sgn);
        logic signed [DATA_W-1:0] s;
        s = DATA_W'($signed(v));
        return sgn ? DATA_W'(s) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] ext32(input logic [31:0] v);
        logic signed [DATA_W-1:0] s;
        s = DATA_W'($signed(v));
        return DATA_W'(s);
    endfunction

    logic [VLO_W-1:0] off_h;
    logic [VLO_W-1:0] off_w;
    logic [7:0]       b_v;
    logic [15:0]      h_v;
    logic [31:0]      w_v;

    // Halfword/word lanes ignore the low offset bits below their natural alignment.
    assign off_h = vaddr_lo & ~VLO_W'(1);
    assign off_w = vaddr_lo & ~VLO_W'(3);
    assign b_v   = 8'(rdata >> {vaddr_lo, 3'b000});
    assign h_v   = 16'(rdata >> {off_h, 3'b000});
    assign w_v   = 32'(rdata >> {off_w, 3'b000});

    always_comb begin
        result = '0;
        case (load_op)
            OP_B:    result = ext8(b_v, 1'b1);
            OP_BU:   result = ext8(b_v, 1'b0);
            OP_H:    result = ext16(h_v, 1'b1);
            OP_HU:   result = ext16(h_v, 1'b0);
            OP_W:    result = ext32(w_v);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ms_load_queue.sv
// In-order memory-stage load queue between EX and WB with flush-discard of late responses.
// Optional MS_LQ_BYPASS_EN: a response for the waiting head is presented to WB in the same cycle.
module ms_load_queue
    import ms_load_queue_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 32,
    parameter  int DEST_W = 5,
    parameter  int PC_W   = 32,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int VLO_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_req,
    input  load_op_t          in_load_op,
    input  logic [VLO_W-1:0]  in_vaddr_lo,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_gr_we,
    input  logic [DATA_W-1:0] in_result,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_gr_we,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_result,
    output logic [PC_W-1:0]   out_pc,
    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_result,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  discard_cnt,
    output logic              proto_err
);

    lq_desc_t          desc_q [DEPTH];
    logic [VLO_W-1:0]  vlo_q  [DEPTH];
    logic [DEST_W-1:0] dest_q [DEPTH];
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  done_q;

    logic [PTR_W-1:0]  rd_ptr, wr_ptr, match_idx;
    logic [CNT_W-1:0]  pend_cnt;
    logic [CNT_W:0]    occupancy;
    logic              pend_found, has_head, head_done, full;
    logic              push, pop, match_hit, match_write, resp_drop, resp_orphan, bypass_hit;
    logic [DATA_W-1:0] align_res;

    // Oldest live entry still waiting for data; responses arrive in request order.
    always_comb begin
        pend_found = 1'b0;
        match_idx  = rd_ptr;
        pend_cnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count && !done_q[rd_ptr + PTR_W'(i)]) begin
                if (!pend_found) begin
                    match_idx  = rd_ptr + PTR_W'(i);
                    pend_found = 1'b1;
                end
                pend_cnt = pend_cnt + CNT_W'(1);
            end
        end
    end

    // Responses owed to flushed loads still hold bus slots, so they count toward full.
    assign occupancy   = {1'b0, count} + {1'b0, discard_cnt};
    assign full        = occupancy >= (CNT_W + 1)'(DEPTH);
    assign resp_drop   = data_sram_data_ok && (discard_cnt != '0);
    assign match_hit   = data_sram_data_ok && (discard_cnt == '0) && pend_found;
    assign resp_orphan = data_sram_data_ok && (discard_cnt == '0) && !pend_found;
    assign has_head    = (count != '0);
    assign head_done   = has_head && done_q[rd_ptr];

`ifdef MS_LQ_BYPASS_EN
    assign bypass_hit = match_hit && has_head && !done_q[rd_ptr] && !flush;
`else
    assign bypass_hit = 1'b0;
`endif

    assign in_ready    = !full && !flush;
    assign push        = in_valid && in_ready;
    assign out_valid   = (head_done || bypass_hit) && !flush;
    assign pop         = out_valid && out_ready;
    assign match_write = match_hit && !(bypass_hit && pop);

    ms_load_align #(.DATA_W(DATA_W)) u_align (
        .rdata    (data_sram_rdata),
        .vaddr_lo (vlo_q[match_idx]),
        .load_op  (desc_q[match_idx].load_op),
        .result   (align_res)
    );

    assign out_gr_we  = has_head && desc_q[rd_ptr].gr_we;
    assign out_dest   = has_head ? dest_q[rd_ptr] : '0;
    assign out_pc     = has_head ? pc_q[rd_ptr] : '0;
    assign out_result = bypass_hit ? align_res : (has_head ? data_q[rd_ptr] : '0);
    assign fwd_valid  = out_valid && out_gr_we;
    assign fwd_dest   = out_dest;
    assign fwd_result = out_result;

    // Control state: pointers, occupancy, discard bookkeeping, completion bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            discard_cnt <= '0;
            proto_err   <= 1'b0;
            done_q      <= '0;
        end else begin
            if (resp_orphan) proto_err <= 1'b1;
            if (flush) begin
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                discard_cnt <= discard_cnt + pend_cnt - CNT_W'(match_hit || resp_drop);
            end else begin
                if (push) begin
                    wr_ptr         <= wr_ptr + PTR_W'(1);
                    done_q[wr_ptr] <= !in_mem_req;
                end
                if (match_write) done_q[match_idx] <= 1'b1;
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                if (resp_drop) discard_cnt <= discard_cnt - CNT_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Entry payload storage; validity is carried entirely by the control state above.
    always_ff @(posedge clk) begin
        if (push) begin
            desc_q[wr_ptr] <= '{gr_we: in_gr_we, load_op: in_load_op};
            vlo_q[wr_ptr]  <= in_vaddr_lo;
            dest_q[wr_ptr] <= in_dest;
            pc_q[wr_ptr]   <= in_pc;
            data_q[wr_ptr] <= in_result;
        end
        if (match_write) data_q[match_idx] <= align_res;
    end

endmodule
